// File: rtl/cmp_search_ctrl.sv
// -----------------------------------------------------------------------------
// cmp_search_ctrl
//
// Initiator side of the magnitude-comparator interface. The comparator already
// holds a target value. This block binary-searches the full WIDTH-bit range by
// driving candidate operands and reading back one-hot equal/less/greater flags.
// A start/done handshake connects it to the sequencer.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        synchronous active-low reset
//   start        request a new search (honoured only while idle)
//   guess        candidate operand driven to comparator input a
//   guess_valid  guess is stable and awaiting a response
//   resp_valid   comparator flags valid this cycle
//   e / l / g    guess ==, <, > target
//   busy         search in progress
//   done         one-cycle pulse at search completion
//   found        last search located the target
//   result       located value (meaningful when found=1)
//   err          last search aborted on non-one-hot flags
//   iter         responses consumed by the last or current search
// -----------------------------------------------------------------------------
module cmp_search_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic [WIDTH-1:0] guess,
    output logic             guess_valid,
    input  logic             resp_valid,
    input  logic             e,
    input  logic             l,
    input  logic             g,
    output logic             busy,
    output logic             done,
    output logic             found,
    output logic [WIDTH-1:0] result,
    output logic             err,
    output logic [WIDTH:0]   iter
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_QUERY,
        S_DONE
    } state_t;

    // Bounds carry one extra bit so lo can reach 2^WIDTH and hi can reach -1.
    localparam logic [WIDTH:0]   MAX_VAL    = {1'b0, {WIDTH{1'b1}}};
    localparam logic [WIDTH-1:0] INIT_GUESS = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH:0]   ONE        = {{WIDTH{1'b0}}, 1'b1};

    state_t           r_state, w_state_nxt;
    logic [WIDTH:0]   r_lo, w_lo_nxt;
    logic [WIDTH:0]   r_hi, w_hi_nxt;
    logic [WIDTH-1:0] r_guess, w_guess_nxt;
    logic [WIDTH-1:0] r_result, w_result_nxt;
    logic             r_found, w_found_nxt;
    logic             r_err, w_err_nxt;
    logic [WIDTH:0]   r_iter, w_iter_nxt;

    logic             w_one_hot;
    logic [WIDTH:0]   w_lo_upd;      // lo after an "l" response
    logic [WIDTH:0]   w_hi_upd;      // hi after a "g" response
    logic             w_l_empty;     // range empty after an "l" response
    logic             w_g_empty;     // range empty after a "g" response
    logic [WIDTH+1:0] w_sum_l;
    logic [WIDTH+1:0] w_sum_g;

    assign w_one_hot = ({e, l, g} == 3'b100) || ({e, l, g} == 3'b010) ||
                       ({e, l, g} == 3'b001);

    assign w_lo_upd = {1'b0, r_guess} + ONE;
    assign w_hi_upd = {1'b0, r_guess} - ONE;

    // lo is never negative, so it is zero-extended; hi may be -1, so it is
    // sign-extended before the signed comparison.
    assign w_l_empty = $signed({1'b0, w_lo_upd}) > $signed({r_hi[WIDTH], r_hi});
    assign w_g_empty = $signed({1'b0, r_lo}) > $signed({w_hi_upd[WIDTH], w_hi_upd});

    // Midpoints are only used when the range is non-empty, where both bounds
    // are non-negative.
    assign w_sum_l = {1'b0, w_lo_upd} + {1'b0, r_hi};
    assign w_sum_g = {1'b0, r_lo} + {1'b0, w_hi_upd};

    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        w_state_nxt  = r_state;
        w_lo_nxt     = r_lo;
        w_hi_nxt     = r_hi;
        w_guess_nxt  = r_guess;
        w_result_nxt = r_result;
        w_found_nxt  = r_found;
        w_err_nxt    = r_err;
        w_iter_nxt   = r_iter;
        busy         = 1'b0;
        guess_valid  = 1'b0;
        done         = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_lo_nxt     = '0;
                    w_hi_nxt     = MAX_VAL;
                    w_guess_nxt  = INIT_GUESS;
                    w_iter_nxt   = '0;
                    w_found_nxt  = 1'b0;
                    w_result_nxt = '0;
                    w_err_nxt    = 1'b0;
                    w_state_nxt  = S_QUERY;
                end
            end

            S_QUERY: begin
                busy        = 1'b1;
                guess_valid = 1'b1;
                if (resp_valid) begin
                    w_iter_nxt = r_iter + ONE;
                    if (!w_one_hot) begin
                        w_err_nxt   = 1'b1;
                        w_found_nxt = 1'b0;
                        w_state_nxt = S_DONE;
                    end else if (e) begin
                        w_found_nxt  = 1'b1;
                        w_result_nxt = r_guess;
                        w_state_nxt  = S_DONE;
                    end else if (l) begin
                        w_lo_nxt = w_lo_upd;
                        if (w_l_empty) begin
                            w_found_nxt = 1'b0;
                            w_state_nxt = S_DONE;
                        end else begin
                            w_guess_nxt = w_sum_l[WIDTH:1];
                        end
                    end else begin
                        w_hi_nxt = w_hi_upd;
                        if (w_g_empty) begin
                            w_found_nxt = 1'b0;
                            w_state_nxt = S_DONE;
                        end else begin
                            w_guess_nxt = w_sum_g[WIDTH:1];
                        end
                    end
                end
            end

            S_DONE: begin
                done        = 1'b1;
                w_state_nxt = S_IDLE;
            end

            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_lo     <= '0;
            r_hi     <= '0;
            r_guess  <= '0;
            r_result <= '0;
            r_found  <= 1'b0;
            r_err    <= 1'b0;
            r_iter   <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_lo     <= w_lo_nxt;
            r_hi     <= w_hi_nxt;
            r_guess  <= w_guess_nxt;
            r_result <= w_result_nxt;
            r_found  <= w_found_nxt;
            r_err    <= w_err_nxt;
            r_iter   <= w_iter_nxt;
        end
    end

    assign guess  = r_guess;
    assign result = r_result;
    assign found  = r_found;
    assign err    = r_err;
    assign iter   = r_iter;

endmodule
